score_keeper: RTL and testbench

//  Multi-player score tracker for the reflex game; successor of the single-channel score counter.

---
 rtl/score_keeper_pkg.sv | 15 +
 rtl/score_keeper_channel.sv | 70 +++++++
 rtl/score_keeper.sv | 144 ++++++++++++++
 tb/tb_score_keeper.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared types and helpers for the reflex-game score keeper and its per-player channels.
package score_keeper_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int LEADER_W = 2;

    function automatic int unsigned score_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/score_keeper_channel.sv
// One player's score: rising-edge qualified hit/miss, saturate or wrap on +1, clamp at 0 on penalty.
module score_channel
    import score_keeper_pkg::*;
#(
    parameter int          SCORE_W   = 6,
    parameter int          WRAP_MODE = 0,
    parameter int unsigned PENALTY   = 1
) (
    input  logic               clk_2,
    input  logic               rst,
    input  logic               hit_i,
    input  logic               miss_i,
    input  logic               freeze_i,
    input  logic               clear_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] score_next_o
);

    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(score_max(SCORE_W));
    localparam logic [SCORE_W-1:0] PEN_STEP  = SCORE_W'(PENALTY);

    logic               hit_q;
    logic               miss_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic               hitEdge;
    logic               missEdge;

    assign hitEdge  = hit_i & ~hit_q;
    assign missEdge = miss_i & ~miss_q;

    // Edge history keeps tracking even while frozen, so a level held across HOLD never scores afterwards.
    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= '0;
        end else begin
            hit_q   <= hit_i;
            miss_q  <= miss_i;
            score_q <= score_d;
        end
    end

    always_comb begin
        score_d = score_q;
        if (clear_i) begin
            score_d = '0;
        end else if (!freeze_i) begin
            if (hitEdge && !missEdge) begin
                if (score_q == MAX_SCORE) begin
                    score_d = (WRAP_MODE != 0) ? '0 : MAX_SCORE;
                end else begin
                    score_d = score_q + SCORE_W'(1);
                end
            end else if (missEdge && !hitEdge) begin
                // A penalty larger than the current score lands on zero rather than underflowing.
                if (32'(score_q) < PENALTY) begin
                    score_d = '0;
                end else begin
                    score_d = score_q - PEN_STEP;
                end
            end
        end
    end

    assign score_o      = score_q;
    assign score_next_o = score_d;

endmodule

// File: rtl/score_keeper.sv
// Multi-player score tracker: per-player channels, PLAY/HOLD round FSM, session high score and leader.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int          N_PLAYERS = 2,
    parameter int          SCORE_W   = 6,
    parameter int          TIMER_W   = 6,
    parameter int          ROUND_END = 31,
    parameter int          WRAP_MODE = 0,
    parameter int unsigned PENALTY   = 1,
    parameter int          HOLD_CYC  = 4
) (
    input  logic                           clk_2,
    input  logic                           rst,
    input  logic [N_PLAYERS-1:0]           hit,
    input  logic [N_PLAYERS-1:0]           miss,
    input  logic [TIMER_W-1:0]             timer_in,
    output logic [N_PLAYERS*SCORE_W-1:0]   score_out,
    output logic [SCORE_W-1:0]             high_score,
    output logic [LEADER_W-1:0]            leader,
    output logic                           round_done,
    output logic                           holding
);

    localparam int                 CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [TIMER_W-1:0] END_VAL  = TIMER_W'(ROUND_END);

    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  arm_q;
    logic                  arm_d;
    logic [SCORE_W-1:0]    high_q;
    logic [SCORE_W-1:0]    high_d;
    logic [LEADER_W-1:0]   leader_q;
    logic [LEADER_W-1:0]   leader_d;
    logic                  roundDone_q;
    logic                  roundDone_d;
    logic                  freeze;
    logic                  clear;
    logic                  atEnd;
    logic [SCORE_W-1:0]    bestScore;
    logic [SCORE_W-1:0]    scoreQ [N_PLAYERS];
    logic [SCORE_W-1:0]    scoreD [N_PLAYERS];

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_ch
        score_channel #(
            .SCORE_W   (SCORE_W),
            .WRAP_MODE (WRAP_MODE),
            .PENALTY   (PENALTY)
        ) u_ch (
            .clk_2        (clk_2),
            .rst          (rst),
            .hit_i        (hit[p]),
            .miss_i       (miss[p]),
            .freeze_i     (freeze),
            .clear_i      (clear),
            .score_o      (scoreQ[p]),
            .score_next_o (scoreD[p])
        );
        assign score_out[p*SCORE_W +: SCORE_W] = scoreQ[p];
    end

    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            state_q     <= PLAY;
            cnt_q       <= '0;
            arm_q       <= 1'b1;
            high_q      <= '0;
            leader_q    <= '0;
            roundDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arm_q       <= arm_d;
            high_q      <= high_d;
            leader_q    <= leader_d;
            roundDone_q <= roundDone_d;
        end
    end

    // The arm flag stops a timer parked on ROUND_END from starting back-to-back rounds.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arm_d       = arm_q;
        high_d      = high_q;
        roundDone_d = 1'b0;
        freeze      = 1'b0;
        clear       = 1'b0;
        atEnd       = (timer_in == END_VAL);
        if (!atEnd) begin
            arm_d = 1'b1;
        end
        case (state_q)
            PLAY: begin
                if (atEnd && arm_q) begin
                    freeze      = 1'b1;
                    arm_d       = 1'b0;
                    roundDone_d = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = HOLD;
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        if (scoreQ[p] > high_d) begin
                            high_d = scoreQ[p];
                        end
                    end
                end
            end
            HOLD: begin
                freeze = 1'b1;
                if (cnt_q == '0) begin
                    clear   = 1'b1;
                    state_d = PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    // Leader is taken from next-state scores so it lands on the same edge as score_out.
    always_comb begin
        leader_d  = '0;
        bestScore = scoreD[0];
        for (int p = 1; p < N_PLAYERS; p++) begin
            if (scoreD[p] > bestScore) begin
                bestScore = scoreD[p];
                leader_d  = LEADER_W'(p);
            end
        end
    end

    assign high_score = high_q;
    assign leader     = leader_q;
    assign round_done = roundDone_q;
    assign holding    = (state_q == HOLD);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: expectations queued with each stimulus step and checked after the clock edge.
module tb_score_keeper;

    localparam int NP = 2;
    localparam int SW = 6;
    localparam int TW = 6;

    logic              clk_2 = 1'b0;
    logic              rst   = 1'b1;
    logic [NP-1:0]     hit   = '0;
    logic [NP-1:0]     miss  = '0;
    logic [TW-1:0]     timer = '0;

    logic [NP*SW-1:0]  scM, scW, scP;
    logic [SW-1:0]     hsM, hsW, hsP;
    logic [1:0]        ldM, ldW, ldP;
    logic              rdM, rdW, rdP;
    logic              hoM, hoW, hoP;

    typedef enum int {S0, S1, HS, LD, RD, HO, W0, P1} sel_e;
    typedef struct {
        string tag;
        sel_e  sel;
        int    exp;
    } exp_t;

    exp_t expQ[$];
    int   nRun  = 0;
    int   nFail = 0;

    always #5 clk_2 = ~clk_2;

    score_keeper #(.WRAP_MODE(0), .PENALTY(1)) dut (
        .clk_2(clk_2), .rst(rst), .hit(hit), .miss(miss), .timer_in(timer),
        .score_out(scM), .high_score(hsM), .leader(ldM), .round_done(rdM), .holding(hoM)
    );

    score_keeper #(.WRAP_MODE(1), .PENALTY(1)) dutWrap (
        .clk_2(clk_2), .rst(rst), .hit(hit), .miss(miss), .timer_in(timer),
        .score_out(scW), .high_score(hsW), .leader(ldW), .round_done(rdW), .holding(hoW)
    );

    score_keeper #(.WRAP_MODE(0), .PENALTY(2)) dutPen (
        .clk_2(clk_2), .rst(rst), .hit(hit), .miss(miss), .timer_in(timer),
        .score_out(scP), .high_score(hsP), .leader(ldP), .round_done(rdP), .holding(hoP)
    );

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S0:      return 32'(scM[0 +: SW]);
            S1:      return 32'(scM[SW +: SW]);
            HS:      return 32'(hsM);
            LD:      return 32'(ldM);
            RD:      return 32'(rdM);
            HO:      return 32'(hoM);
            W0:      return 32'(scW[0 +: SW]);
            P1:      return 32'(scP[SW +: SW]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic applyStimulus(input string tag, input sel_e s, input int e);
        expQ.push_back('{tag, s, e});
    endtask

    task automatic checkOutput(input bit waitEdge);
        exp_t        t;
        logic [31:0] obs;
        if (waitEdge) tick();
        while (expQ.size() > 0) begin
            t   = expQ.pop_front();
            obs = observe(t.sel);
            nRun++;
            assert (obs === 32'(t.exp))
            else begin
                nFail++;
                $error("[TB] FAIL %s: observed %0d expected %0d", t.tag, obs, t.exp);
            end
        end
    endtask

    task automatic pulse(input logic [NP-1:0] h, input logic [NP-1:0] m);
        hit  = h;
        miss = m;
        tick();
        hit  = '0;
        miss = '0;
        tick();
    endtask

    initial begin
        // Reset values
        repeat (2) tick();
        applyStimulus("rstScore0", S0, 0);
        applyStimulus("rstScore1", S1, 0);
        applyStimulus("rstHigh", HS, 0);
        applyStimulus("rstLeader", LD, 0);
        applyStimulus("rstRoundDone", RD, 0);
        applyStimulus("rstHolding", HO, 0);
        checkOutput(0);
        rst = 1'b0;
        tick();

        // Build scores {5,3}
        for (int i = 0; i < 5; i++) begin
            pulse((i < 3) ? 2'b11 : 2'b01, 2'b00);
        end
        applyStimulus("build0", S0, 5);
        applyStimulus("build1", S1, 3);
        applyStimulus("buildLeader", LD, 0);
        checkOutput(0);

        // Asynchronous reset mid-round
        #2;
        rst = 1'b1;
        #1;
        applyStimulus("asyncRst0", S0, 0);
        applyStimulus("asyncRst1", S1, 0);
        applyStimulus("asyncRstLeader", LD, 0);
        checkOutput(0);
        rst = 1'b0;

        // First edge after reset scores from zero, one edge of latency
        hit = 2'b01;
        applyStimulus("firstEdge", S0, 1);
        checkOutput(1);
        repeat (10) tick();
        applyStimulus("heldHigh0", S0, 1);
        applyStimulus("heldHigh1", S1, 0);
        checkOutput(0);
        repeat (2) begin
            hit = 2'b00;
            tick();
            hit = 2'b01;
            tick();
        end
        applyStimulus("toggle", S0, 3);
        checkOutput(0);
        hit = 2'b00;
        tick();

        // Miss clamp, simultaneous hit+miss, penalty sizes
        miss = 2'b10;
        applyStimulus("missClamp", S1, 0);
        checkOutput(1);
        miss = 2'b00;
        tick();
        repeat (4) pulse(2'b10, 2'b00);
        hit  = 2'b10;
        miss = 2'b10;
        applyStimulus("hitMissSame", S1, 4);
        checkOutput(1);
        hit  = 2'b00;
        miss = 2'b00;
        tick();
        miss = 2'b10;
        applyStimulus("penalty1", S1, 3);
        applyStimulus("penalty2", P1, 2);
        applyStimulus("tieLeader", LD, 0);
        checkOutput(1);
        miss = 2'b00;
        tick();

        // Round end with scores {7,9}
        repeat (4) pulse(2'b11, 2'b00);
        repeat (2) pulse(2'b10, 2'b00);
        applyStimulus("preEnd0", S0, 7);
        applyStimulus("preEnd1", S1, 9);
        applyStimulus("preEndLeader", LD, 1);
        checkOutput(0);
        hit   = 2'b01;
        timer = TW'(31);
        applyStimulus("edgeAtEnd", S0, 7);
        applyStimulus("highScore", HS, 9);
        applyStimulus("roundDone", RD, 1);
        applyStimulus("hold1", HO, 1);
        checkOutput(1);
        hit = 2'b00;
        applyStimulus("rdPulse", RD, 0);
        applyStimulus("hold2", HO, 1);
        applyStimulus("holdLeader", LD, 1);
        checkOutput(1);
        hit = 2'b01;
        applyStimulus("holdIgnore", S0, 7);
        applyStimulus("hold3", HO, 1);
        checkOutput(1);
        hit = 2'b00;
        applyStimulus("hold4", HO, 1);
        checkOutput(1);
        applyStimulus("holdExit", HO, 0);
        applyStimulus("clear0", S0, 0);
        applyStimulus("clear1", S1, 0);
        applyStimulus("clearLeader", LD, 0);
        checkOutput(1);

        // Timer parked on ROUND_END must not start another round
        for (int i = 0; i < 3; i++) begin
            applyStimulus("noRearmRd", RD, 0);
            applyStimulus("noRearmHold", HO, 0);
            checkOutput(1);
        end
        timer = '0;
        tick();
        timer = TW'(31);
        applyStimulus("rearm", RD, 1);
        applyStimulus("rearmHigh", HS, 9);
        checkOutput(1);

        // Reset mid-HOLD clears the session high score too
        #2;
        rst = 1'b1;
        #1;
        applyStimulus("holdRstHigh", HS, 0);
        applyStimulus("holdRstHolding", HO, 0);
        applyStimulus("holdRstRd", RD, 0);
        applyStimulus("holdRstScore", S0, 0);
        checkOutput(0);
        timer = '0;
        rst   = 1'b0;
        tick();

        // Saturate versus wrap at max score
        repeat (63) pulse(2'b01, 2'b00);
        applyStimulus("atMaxSat", S0, 63);
        applyStimulus("atMaxWrap", W0, 63);
        checkOutput(0);
        hit = 2'b01;
        applyStimulus("saturate", S0, 63);
        applyStimulus("wrap", W0, 0);
        applyStimulus("satHigh", HS, 0);
        checkOutput(1);
        hit = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
